mmu_arbiter: RTL and testbench



---
 rtl/mmu_pkg.sv | 36 +++
 rtl/mmu_line_buffer.sv | 34 +++
 rtl/mmu_arbiter.sv | 219 +++++++++++++++++++++
 tb/tb_mmu_arbiter.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmu_pkg.sv
// Shared types and width helpers for the MMU arbiter slice.
package mmu_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SRAM_ACC,
      SRAM_RSP,
      PMEM_BURST,
      RESP
   } mmu_state_e;

   typedef enum logic {
      GRANT_I,
      GRANT_D
   } grant_e;

   localparam int unsigned DEF_DW        = 32;
   localparam int unsigned DEF_BURST_LEN = 4;

   function automatic int unsigned byte_off_w(input int unsigned dw);
      return $clog2(dw / 8);
   endfunction

   function automatic int unsigned line_off_w(input int unsigned dw, input int unsigned bl);
      return $clog2(bl * dw / 8);
   endfunction

   // Beat counter never collapses to zero bits, even for single-beat lines.
   function automatic int unsigned beat_w(input int unsigned bl);
      return (bl > 1) ? $clog2(bl) : 1;
   endfunction

   localparam int unsigned BYTE_OFF_W = byte_off_w(DEF_DW);
   localparam int unsigned LINE_OFF_W = line_off_w(DEF_DW, DEF_BURST_LEN);

endpackage

// File: rtl/mmu_line_buffer.sv
// Instruction line assembly buffer: one DW slot per burst beat, beat 0 in the LSBs.
module mmu_line_buffer
   import mmu_pkg::*;
#(
   parameter int unsigned DW        = 32,
   parameter int unsigned BURST_LEN = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           wr_en,
   input  logic [beat_w(BURST_LEN)-1:0]   wr_idx,
   input  logic [DW-1:0]                  wr_data,
   output logic [BURST_LEN*DW-1:0]        line
);

   localparam int unsigned IDX_W = beat_w(BURST_LEN);

   logic [BURST_LEN*DW-1:0] line_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         line_q <= '0;
      end else if (wr_en) begin
         for (int i = 0; i < BURST_LEN; i++) begin
            if (wr_idx == IDX_W'(i)) begin
               line_q[i*DW +: DW] <= wr_data;
            end
         end
      end
   end

   assign line = line_q;

endmodule

// File: rtl/mmu_arbiter.sv
// Arbitrates instruction line fills and data word accesses onto an on-chip
// SRAM window and off-chip pmem; pmem fills run as counted bursts.
module mmu_arbiter
   import mmu_pkg::*;
#(
   parameter int unsigned    AW          = 32,
   parameter int unsigned    DW          = 32,
   parameter int unsigned    BURST_LEN   = 4,
   parameter int unsigned    SRAM_AW     = 10,
   parameter logic [AW-1:0]  ONCHIP_BASE = AW'(32'h8000_0000)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_req,
   input  logic [AW-1:0]            i_addr,
   output logic                     i_resp,
   output logic [BURST_LEN*DW-1:0]  i_line,
   input  logic                     d_req,
   input  logic                     d_we,
   input  logic [AW-1:0]            d_addr,
   input  logic [DW-1:0]            d_wdata,
   output logic [DW-1:0]            d_rdata,
   output logic                     d_resp,
   output logic                     pmem_read,
   output logic                     pmem_write,
   output logic [AW-1:0]            pmem_addr,
   output logic [DW-1:0]            pmem_wdata,
   input  logic [DW-1:0]            pmem_rdata,
   input  logic                     pmem_resp,
   output logic                     sram_en,
   output logic                     sram_we,
   output logic [SRAM_AW-1:0]       sram_addr,
   output logic [DW-1:0]            sram_wdata,
   input  logic [DW-1:0]            sram_rdata,
   output logic                     busy
);

   localparam int unsigned   BYTE_OFF    = byte_off_w(DW);
   localparam int unsigned   LINE_OFF    = line_off_w(DW, BURST_LEN);
   localparam int unsigned   BEAT_W      = beat_w(BURST_LEN);
   localparam int unsigned   WIN_LSB     = SRAM_AW + BYTE_OFF;
   localparam logic [BEAT_W-1:0] LAST_I_BEAT = BEAT_W'(BURST_LEN - 1);

   mmu_state_e          state_q, state_d;
   grant_e              grant_q, grant_d;
   grant_e              last_grant_q, last_grant_d;
   logic [BEAT_W-1:0]   beat_q, beat_d;
   logic [AW-1:0]       addr_q, addr_d;
   logic                we_q, we_d;
   logic [DW-1:0]       wdata_q, wdata_d;
   logic [DW-1:0]       rdata_q, rdata_d;
   logic                line_we;
   logic [BEAT_W-1:0]   last_beat;
   logic [AW-1:0]       d_win_off;
   logic                d_in_win;
   logic [AW-1:0]       win_off_d;

   // Next-cycle values of the registered outputs.
   logic                i_resp_d, d_resp_d, busy_d;
   logic                pmem_read_d, pmem_write_d;
   logic [AW-1:0]       pmem_addr_d;
   logic [DW-1:0]       pmem_wdata_d;
   logic                sram_en_d, sram_we_d;
   logic [SRAM_AW-1:0]  sram_addr_d;
   logic [DW-1:0]       sram_wdata_d;

   // Window is aligned, so membership is "offset from base has no bits above the window".
   assign d_win_off = d_addr - ONCHIP_BASE;
   assign d_in_win  = ((d_win_off >> WIN_LSB) == '0);
   assign last_beat = (grant_q == GRANT_I) ? LAST_I_BEAT : '0;

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      beat_d       = beat_q;
      addr_d       = addr_q;
      we_d         = we_q;
      wdata_d      = wdata_q;
      rdata_d      = rdata_q;
      line_we      = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (i_req || d_req) begin
               if (i_req && d_req) begin
                  grant_d = (last_grant_q == GRANT_I) ? GRANT_D : GRANT_I;
               end else begin
                  grant_d = d_req ? GRANT_D : GRANT_I;
               end
               beat_d = '0;
               if (grant_d == GRANT_I) begin
                  addr_d  = (i_addr >> LINE_OFF) << LINE_OFF;
                  we_d    = 1'b0;
                  wdata_d = '0;
                  state_d = PMEM_BURST;
               end else begin
                  addr_d  = (d_addr >> BYTE_OFF) << BYTE_OFF;
                  we_d    = d_we;
                  wdata_d = d_wdata;
                  state_d = d_in_win ? SRAM_ACC : PMEM_BURST;
               end
            end
         end
         SRAM_ACC: begin
            state_d = SRAM_RSP;
         end
         SRAM_RSP: begin
            if (!we_q) begin
               rdata_d = sram_rdata;
            end
            last_grant_d = GRANT_D;
            state_d      = IDLE;
         end
         PMEM_BURST: begin
            if (pmem_resp) begin
               if (grant_q == GRANT_I) begin
                  line_we = 1'b1;
               end else if (!we_q) begin
                  rdata_d = pmem_rdata;
               end
               if (beat_q == last_beat) begin
                  beat_d  = '0;
                  state_d = RESP;
               end else begin
                  beat_d = beat_q + BEAT_W'(1);
               end
            end
         end
         RESP: begin
            last_grant_d = grant_q;
            state_d      = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Registered outputs are derived from the state being entered.
      win_off_d    = addr_d - ONCHIP_BASE;
      sram_en_d    = (state_d == SRAM_ACC);
      sram_we_d    = sram_en_d && we_d;
      sram_addr_d  = sram_en_d ? SRAM_AW'(win_off_d >> BYTE_OFF) : '0;
      sram_wdata_d = sram_we_d ? wdata_d : '0;
      pmem_read_d  = (state_d == PMEM_BURST) && !we_d;
      pmem_write_d = (state_d == PMEM_BURST) && we_d;
      pmem_addr_d  = (state_d == PMEM_BURST) ? addr_d + (AW'(beat_d) << BYTE_OFF) : '0;
      pmem_wdata_d = pmem_write_d ? wdata_d : '0;
      i_resp_d     = (state_d == RESP) && (grant_d == GRANT_I);
      d_resp_d     = (state_d == SRAM_RSP) || ((state_d == RESP) && (grant_d == GRANT_D));
      busy_d       = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         grant_q      <= GRANT_I;
         last_grant_q <= GRANT_I;
         beat_q       <= '0;
         addr_q       <= '0;
         we_q         <= 1'b0;
         wdata_q      <= '0;
         rdata_q      <= '0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         beat_q       <= beat_d;
         addr_q       <= addr_d;
         we_q         <= we_d;
         wdata_q      <= wdata_d;
         rdata_q      <= rdata_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         i_resp     <= 1'b0;
         d_resp     <= 1'b0;
         busy       <= 1'b0;
         pmem_read  <= 1'b0;
         pmem_write <= 1'b0;
         pmem_addr  <= '0;
         pmem_wdata <= '0;
         sram_en    <= 1'b0;
         sram_we    <= 1'b0;
         sram_addr  <= '0;
         sram_wdata <= '0;
      end else begin
         i_resp     <= i_resp_d;
         d_resp     <= d_resp_d;
         busy       <= busy_d;
         pmem_read  <= pmem_read_d;
         pmem_write <= pmem_write_d;
         pmem_addr  <= pmem_addr_d;
         pmem_wdata <= pmem_wdata_d;
         sram_en    <= sram_en_d;
         sram_we    <= sram_we_d;
         sram_addr  <= sram_addr_d;
         sram_wdata <= sram_wdata_d;
      end
   end

   // SRAM load data arrives in the response cycle itself, so it bypasses the hold register.
   assign d_rdata = ((state_q == SRAM_RSP) && !we_q) ? sram_rdata : rdata_q;

   mmu_line_buffer #(
      .DW        (DW),
      .BURST_LEN (BURST_LEN)
   ) u_line_buffer (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (line_we),
      .wr_idx  (beat_q),
      .wr_data (pmem_rdata),
      .line    (i_line)
   );

endmodule

// File: tb/tb_mmu_arbiter.sv
// Directed self-checking bench for mmu_arbiter at default parameters.
module tb_mmu_arbiter;

   logic          clk = 1'b0;
   logic          rst;
   logic          i_req;
   logic [31:0]   i_addr;
   logic          i_resp;
   logic [127:0]  i_line;
   logic          d_req;
   logic          d_we;
   logic [31:0]   d_addr;
   logic [31:0]   d_wdata;
   logic [31:0]   d_rdata;
   logic          d_resp;
   logic          pmem_read;
   logic          pmem_write;
   logic [31:0]   pmem_addr;
   logic [31:0]   pmem_wdata;
   logic [31:0]   pmem_rdata;
   logic          pmem_resp;
   logic          sram_en;
   logic          sram_we;
   logic [9:0]    sram_addr;
   logic [31:0]   sram_wdata;
   logic [31:0]   sram_rdata;
   logic          busy;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   mmu_arbiter dut (
      .clk        (clk),
      .rst        (rst),
      .i_req      (i_req),
      .i_addr     (i_addr),
      .i_resp     (i_resp),
      .i_line     (i_line),
      .d_req      (d_req),
      .d_we       (d_we),
      .d_addr     (d_addr),
      .d_wdata    (d_wdata),
      .d_rdata    (d_rdata),
      .d_resp     (d_resp),
      .pmem_read  (pmem_read),
      .pmem_write (pmem_write),
      .pmem_addr  (pmem_addr),
      .pmem_wdata (pmem_wdata),
      .pmem_rdata (pmem_rdata),
      .pmem_resp  (pmem_resp),
      .sram_en    (sram_en),
      .sram_we    (sram_we),
      .sram_addr  (sram_addr),
      .sram_wdata (sram_wdata),
      .sram_rdata (sram_rdata),
      .busy       (busy)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
      n_checks++; if ({pmem_read, pmem_write, sram_en, sram_we} !== 4'b0) $display("FAIL reset_strobes: got %b want 0000", {pmem_read, pmem_write, sram_en, sram_we}); else n_pass++;
      n_checks++; if ({i_resp, d_resp} !== 2'b00) $display("FAIL reset_resp: got %b want 00", {i_resp, d_resp}); else n_pass++;
      n_checks++; if (i_line !== 128'h0) $display("FAIL reset_i_line: got %h want 0", i_line); else n_pass++;
      n_checks++; if (d_rdata !== 32'h0) $display("FAIL reset_d_rdata: got %h want 0", d_rdata); else n_pass++;
      n_checks++; if (pmem_addr !== 32'h0) $display("FAIL reset_pmem_addr: got %h want 0", pmem_addr); else n_pass++;
      rst = 1'b0;
      step();
   endtask

   task automatic test_tie_break();
      for (int pair = 0; pair < 2; pair++) begin
         int  order [2];
         int  n       = 0;
         bit  overlap = 1'b0;
         order[0] = 0;
         order[1] = 0;
         i_req  = 1'b1;
         i_addr = 32'h0000_0100;
         d_req  = 1'b1;
         d_we   = 1'b0;
         d_addr = 32'h8000_0008;
         for (int c = 0; c < 40 && n < 2; c++) begin
            step();
            pmem_resp  = pmem_read;
            pmem_rdata = 32'h0;
            if (i_resp && d_resp) overlap = 1'b1;
            if (d_resp) begin
               if (n < 2) order[n] = 1;
               n++;
               d_req = 1'b0;
            end
            if (i_resp) begin
               if (n < 2) order[n] = 2;
               n++;
               i_req = 1'b0;
            end
         end
         pmem_resp = 1'b0;
         i_req     = 1'b0;
         d_req     = 1'b0;
         n_checks++; if (n != 2) $display("FAIL tie_pair%0d_done: got %0d responses want 2 within budget", pair, n); else n_pass++;
         n_checks++; if (order[0] != 1) $display("FAIL tie_pair%0d_first: got %0d want 1 (data)", pair, order[0]); else n_pass++;
         n_checks++; if (order[1] != 2) $display("FAIL tie_pair%0d_second: got %0d want 2 (instr)", pair, order[1]); else n_pass++;
         n_checks++; if (overlap) $display("FAIL tie_pair%0d_overlap: got i_resp and d_resp together want never", pair); else n_pass++;
         step();
      end
   endtask

   task automatic test_sram_store_load();
      d_req   = 1'b1;
      d_we    = 1'b1;
      d_addr  = 32'h8000_0010;
      d_wdata = 32'hDEAD_BEEF;
      step();
      n_checks++; if ({sram_en, sram_we} !== 2'b11) $display("FAIL sram_st_strobe: got %b want 11", {sram_en, sram_we}); else n_pass++;
      n_checks++; if (sram_addr !== 10'd4) $display("FAIL sram_st_addr: got %0d want 4", sram_addr); else n_pass++;
      n_checks++; if (sram_wdata !== 32'hDEAD_BEEF) $display("FAIL sram_st_wdata: got %h want deadbeef", sram_wdata); else n_pass++;
      n_checks++; if (d_resp !== 1'b0) $display("FAIL sram_st_early_resp: got %b want 0", d_resp); else n_pass++;
      step();
      n_checks++; if ({d_resp, busy, sram_en} !== 3'b110) $display("FAIL sram_st_resp: got %b want 110", {d_resp, busy, sram_en}); else n_pass++;
      d_req = 1'b0;
      step();
      n_checks++; if ({d_resp, busy} !== 2'b00) $display("FAIL sram_st_idle: got %b want 00", {d_resp, busy}); else n_pass++;

      d_req = 1'b1;
      d_we  = 1'b0;
      step();
      n_checks++; if ({sram_en, sram_we, sram_addr} !== {2'b10, 10'd4}) $display("FAIL sram_ld_cmd: got %b %0d want 10 4", {sram_en, sram_we}, sram_addr); else n_pass++;
      sram_rdata = 32'hDEAD_BEEF;
      step();
      n_checks++; if (d_resp !== 1'b1) $display("FAIL sram_ld_resp: got %b want 1", d_resp); else n_pass++;
      n_checks++; if (d_rdata !== 32'hDEAD_BEEF) $display("FAIL sram_ld_data: got %h want deadbeef", d_rdata); else n_pass++;
      d_req = 1'b0;
      step();
      sram_rdata = 32'h0;
      #1;
      n_checks++; if (d_rdata !== 32'hDEAD_BEEF) $display("FAIL sram_ld_hold: got %h want deadbeef", d_rdata); else n_pass++;
   endtask

   task automatic test_line_fill();
      i_req  = 1'b1;
      i_addr = 32'h0000_104C;
      for (int k = 0; k < 4; k++) begin
         logic [31:0] exp_addr;
         exp_addr = 32'h0000_1040 + 32'(4 * k);
         step();
         n_checks++; if ({pmem_read, pmem_addr} !== {1'b1, exp_addr}) $display("FAIL fill_beat%0d: got %b %h want 1 %h", k, pmem_read, pmem_addr, exp_addr); else n_pass++;
         pmem_resp  = 1'b1;
         pmem_rdata = 32'(k);
      end
      step();
      pmem_resp  = 1'b0;
      pmem_rdata = 32'h0;
      n_checks++; if ({i_resp, d_resp, pmem_read} !== 3'b100) $display("FAIL fill_resp: got %b want 100", {i_resp, d_resp, pmem_read}); else n_pass++;
      n_checks++; if (i_line !== 128'h00000003_00000002_00000001_00000000) $display("FAIL fill_line: got %h want 3_2_1_0", i_line); else n_pass++;
      i_req = 1'b0;
      step();
      n_checks++; if ({i_resp, busy} !== 2'b00) $display("FAIL fill_after: got %b want 00", {i_resp, busy}); else n_pass++;
      n_checks++; if (i_line !== 128'h00000003_00000002_00000001_00000000) $display("FAIL fill_hold: got %h want 3_2_1_0", i_line); else n_pass++;
   endtask

   task automatic test_offchip_load();
      int read_cycles = 0;
      d_req  = 1'b1;
      d_we   = 1'b0;
      d_addr = 32'h0000_2000;
      for (int k = 1; k <= 4; k++) begin
         step();
         if (pmem_read && pmem_addr == 32'h0000_2000) read_cycles++;
         if (k == 4) begin
            pmem_resp  = 1'b1;
            pmem_rdata = 32'hCAFE_F00D;
         end
      end
      step();
      pmem_resp  = 1'b0;
      pmem_rdata = 32'h0;
      n_checks++; if (read_cycles != 4) $display("FAIL offchip_read_len: got %0d want 4", read_cycles); else n_pass++;
      n_checks++; if ({d_resp, i_resp, pmem_read} !== 3'b100) $display("FAIL offchip_one_beat: got %b want 100", {d_resp, i_resp, pmem_read}); else n_pass++;
      n_checks++; if (d_rdata !== 32'hCAFE_F00D) $display("FAIL offchip_data: got %h want cafef00d", d_rdata); else n_pass++;
      d_req = 1'b0;
      step();
      n_checks++; if ({d_resp, d_rdata} !== {1'b0, 32'hCAFE_F00D}) $display("FAIL offchip_hold: got %b %h want 0 cafef00d", d_resp, d_rdata); else n_pass++;
   endtask

   task automatic test_wrap_edge();
      i_req  = 1'b1;
      i_addr = 32'hFFFF_FFF0;
      for (int k = 0; k < 4; k++) begin
         logic [31:0] exp_addr;
         exp_addr = 32'hFFFF_FFF0 + 32'(4 * k);
         step();
         n_checks++; if ({pmem_read, pmem_addr} !== {1'b1, exp_addr}) $display("FAIL wrap_beat%0d: got %b %h want 1 %h", k, pmem_read, pmem_addr, exp_addr); else n_pass++;
         pmem_resp = 1'b1;
      end
      step();
      pmem_resp = 1'b0;
      n_checks++; if (i_resp !== 1'b1) $display("FAIL wrap_resp: got %b want 1", i_resp); else n_pass++;
      i_req = 1'b0;
      step();

      d_req   = 1'b1;
      d_we    = 1'b1;
      d_addr  = 32'h8000_1000;
      d_wdata = 32'h1234_5678;
      step();
      n_checks++; if ({sram_en, pmem_write, pmem_read} !== 3'b010) $display("FAIL edge_route: got %b want 010", {sram_en, pmem_write, pmem_read}); else n_pass++;
      n_checks++; if ({pmem_addr, pmem_wdata} !== {32'h8000_1000, 32'h1234_5678}) $display("FAIL edge_pmem_cmd: got %h %h want 80001000 12345678", pmem_addr, pmem_wdata); else n_pass++;
      pmem_resp = 1'b1;
      step();
      pmem_resp = 1'b0;
      n_checks++; if ({d_resp, pmem_write} !== 2'b10) $display("FAIL edge_resp: got %b want 10", {d_resp, pmem_write}); else n_pass++;
      d_req = 1'b0;
      step();

      d_req  = 1'b1;
      d_we   = 1'b0;
      d_addr = 32'h8000_0FFC;
      step();
      n_checks++; if ({sram_en, pmem_read, sram_addr} !== {2'b10, 10'h3FF}) $display("FAIL edge_last_word: got %b %h want 10 3ff", {sram_en, pmem_read}, sram_addr); else n_pass++;
      step();
      n_checks++; if (d_resp !== 1'b1) $display("FAIL edge_last_resp: got %b want 1", d_resp); else n_pass++;
      d_req = 1'b0;
      step();
   endtask

   task automatic test_reset_mid_burst();
      i_req  = 1'b1;
      i_addr = 32'h0000_3000;
      step();
      pmem_resp  = 1'b1;
      pmem_rdata = 32'hAA;
      step();
      pmem_rdata = 32'hBB;
      step();
      rst       = 1'b1;
      i_req     = 1'b0;
      pmem_resp = 1'b0;
      step();
      n_checks++; if ({busy, pmem_read} !== 2'b00) $display("FAIL midrst_idle: got %b want 00", {busy, pmem_read}); else n_pass++;
      n_checks++; if (i_line !== 128'h0) $display("FAIL midrst_line: got %h want 0", i_line); else n_pass++;
      rst    = 1'b0;
      i_req  = 1'b1;
      step();
      n_checks++; if ({pmem_read, pmem_addr} !== {1'b1, 32'h0000_3000}) $display("FAIL midrst_restart: got %b %h want 1 00003000", pmem_read, pmem_addr); else n_pass++;
      pmem_resp  = 1'b1;
      pmem_rdata = 32'h10;
      for (int k = 1; k < 4; k++) begin
         step();
         pmem_rdata = 32'h10 + 32'(k);
      end
      step();
      pmem_resp  = 1'b0;
      pmem_rdata = 32'h0;
      n_checks++; if (i_resp !== 1'b1) $display("FAIL midrst_resp: got %b want 1", i_resp); else n_pass++;
      n_checks++; if (i_line !== 128'h00000013_00000012_00000011_00000010) $display("FAIL midrst_line_new: got %h want 13_12_11_10", i_line); else n_pass++;
      i_req = 1'b0;
      step();
   endtask

   initial begin
      rst        = 1'b1;
      i_req      = 1'b0;
      i_addr     = 32'h0;
      d_req      = 1'b0;
      d_we       = 1'b0;
      d_addr     = 32'h0;
      d_wdata    = 32'h0;
      pmem_rdata = 32'h0;
      pmem_resp  = 1'b0;
      sram_rdata = 32'h0;
      test_reset();
      test_tie_break();
      test_sram_store_load();
      test_line_fill();
      test_offchip_load();
      test_wrap_edge();
      test_reset_mid_burst();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
